// File: rtl/signed_calc_arb_v.sv
// signed_calc_arb_v
// Shares one combinational signed_calc_v datapath between two requesters.
// Requests are granted round-robin. The granted 5-bit signed operand pair is
// registered onto the calculator inputs and held for SETTLE cycles. The 9-bit
// signed result is then captured and returned on a valid/ready response
// channel, tagged with the id of the requester that issued it. The block only
// moves operands and results; it performs no arithmetic itself.
//
// Ports
//   i_clk, i_rst                   clock (rising edge), async active-high reset
//   i_req_valid_0/1                request valid from requester 0 / 1
//   i_as_0, i_bs_0, i_as_1, i_bs_1 signed operand pairs from each requester
//   o_req_ready_0/1                request accepted this cycle (combinational)
//   o_as, o_bs                     registered operands to signed_calc_v
//   i_fs                           result from signed_calc_v
//   o_rsp_valid, o_rsp_id          response valid and owning requester
//   o_rsp_fs                       captured result
//   i_rsp_ready                    response consumer ready
//   o_busy                         high whenever the sequencer is not idle
module signed_calc_arb_v #(
  parameter int SETTLE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid_0,
  input  logic              i_req_valid_1,
  input  logic signed [4:0] i_as_0,
  input  logic signed [4:0] i_bs_0,
  input  logic signed [4:0] i_as_1,
  input  logic signed [4:0] i_bs_1,
  output logic              o_req_ready_0,
  output logic              o_req_ready_1,
  output logic signed [4:0] o_as,
  output logic signed [4:0] o_bs,
  input  logic signed [8:0] i_fs,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic signed [8:0] o_rsp_fs,
  input  logic              i_rsp_ready,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] settle_cnt;
  logic       last;
  logic       winner;
  logic       accept;
  logic       idle_live;

  // Round-robin choice: on a tie the requester not served last wins,
  // otherwise whichever single requester is asking wins.
  always_comb begin
    winner = i_req_valid_1;
    if (i_req_valid_0 && i_req_valid_1) begin
      winner = ~last;
    end
  end

  // Readies are qualified with reset so nothing is offered while reset is
  // still held, even though the state register already reads IDLE.
  assign idle_live     = (state == ST_IDLE) && !i_rst;
  assign o_req_ready_0 = idle_live && i_req_valid_0 && !winner;
  assign o_req_ready_1 = idle_live && i_req_valid_1 && winner;
  assign accept        = (state == ST_IDLE) && (i_req_valid_0 || i_req_valid_1);

  assign o_rsp_valid = (state == ST_RESP);
  assign o_busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept -> settle countdown -> hold response until taken.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (i_req_valid_0 || i_req_valid_1) begin
          next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 4'd0) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: operands, tag and pointer are loaded only on accept, so they
  // stay frozen through SETTLE and RESP. The result is sampled exactly once,
  // on the edge where the countdown expires; later i_fs changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_as       <= '0;
      o_bs       <= '0;
      o_rsp_id   <= 1'b0;
      o_rsp_fs   <= '0;
      last       <= 1'b1;
      settle_cnt <= 4'd0;
    end else begin
      if (accept) begin
        o_as       <= winner ? i_as_1 : i_as_0;
        o_bs       <= winner ? i_bs_1 : i_bs_0;
        o_rsp_id   <= winner;
        last       <= winner;
        settle_cnt <= SETTLE_LOAD;
      end else if (state == ST_SETTLE) begin
        if (settle_cnt == 4'd0) begin
          o_rsp_fs <= i_fs;
        end else begin
          settle_cnt <= settle_cnt - 4'd1;
        end
      end
    end
  end

endmodule
